// File: rtl/uart_tx_dev_pkg.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_dev_pkg
// Brief   : Register map, bit indices, FSM encoding and bridge windows.
// Revision: 1.0  initial release
// ============================================================================
package uart_tx_dev_pkg;

    // Bridge device windows (byte addresses, inclusive)
    localparam logic [31:0] TIMER0_WIN_LO = 32'h0000_7F00;
    localparam logic [31:0] TIMER0_WIN_HI = 32'h0000_7F0B;
    localparam logic [31:0] TIMER1_WIN_LO = 32'h0000_7F10;
    localparam logic [31:0] TIMER1_WIN_HI = 32'h0000_7F1B;
    localparam logic [31:0] UART_WIN_LO   = 32'h0000_7F30;
    localparam logic [31:0] UART_WIN_HI   = 32'h0000_7F3F;

    // Register offsets, decoded from Addr[3:2]
    localparam logic [1:0] UART_DATA = 2'd0;
    localparam logic [1:0] UART_CTRL = 2'd1;
    localparam logic [1:0] UART_STAT = 2'd2;
    localparam logic [1:0] UART_DIV  = 2'd3;

    localparam int CTRL_EN  = 0;
    localparam int CTRL_IEN = 1;

    localparam int STAT_BUSY  = 0;
    localparam int STAT_FULL  = 1;
    localparam int STAT_EMPTY = 2;
    localparam int STAT_DONE  = 3;
    localparam int STAT_OVF   = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_fifo
// Brief   : Synchronous FIFO with extra-bit pointers; push on full is
//           accepted only when a pop happens in the same cycle.
// Revision: 1.0  initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);

    localparam int         AW      = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             w_do_push, w_do_pop;

    assign o_empty   = (wr_ptr_q == rd_ptr_q);
    assign o_full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_dout    = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (w_do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (w_do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage carries no reset; the pointers alone define validity.
    always_ff @(posedge clk) begin
        if (w_do_push) mem_q[wr_ptr_q[AW-1:0]] <= i_din;
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_dev.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_dev
// Brief   : Memory-mapped 8N1 UART transmitter with TX FIFO and level IRQ.
// Revision: 1.0  initial release
// ============================================================================
module uart_tx_dev
    import uart_tx_dev_pkg::*;
#(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] DIV_RESET  = 16'd868
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:2] Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ,
    output logic        txd
);

    uart_state_e state_q, state_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [15:0] baud_cnt_q, baud_cnt_d;
    logic [15:0] wdiv_q, wdiv_d;
    logic [15:0] div_q, div_d;
    logic        ctrl_en_q, ctrl_en_d;
    logic        ctrl_ien_q, ctrl_ien_d;
    logic        done_q, done_d;
    logic        ovf_q, ovf_d;

    logic        w_wr_data, w_wr_ctrl, w_wr_stat, w_wr_div;
    logic        w_pop, w_push, w_full, w_empty, w_ovf_set, w_done_set;
    logic        w_bit_end;
    logic [15:0] w_dlim_m1;
    logic [7:0]  w_fifo_dout;
    logic [4:0]  w_stat;
    logic        w_unused_bits;

    assign w_unused_bits = ^{Addr[31:4], Din[31:16]};

    assign w_wr_data = WE && (Addr[3:2] == UART_DATA);
    assign w_wr_ctrl = WE && (Addr[3:2] == UART_CTRL);
    assign w_wr_stat = WE && (Addr[3:2] == UART_STAT);
    assign w_wr_div  = WE && (Addr[3:2] == UART_DIV);

    // A pop in the same cycle frees the slot, so a write to a full FIFO is kept.
    assign w_push    = w_wr_data && (!w_full || w_pop);
    assign w_ovf_set = w_wr_data && w_full && !w_pop;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .i_push  (w_push),
        .i_din   (Din[7:0]),
        .i_pop   (w_pop),
        .o_dout  (w_fifo_dout),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // A latched divisor of 0 behaves as 1.
    assign w_dlim_m1 = (wdiv_q == 16'd0) ? 16'd0 : (wdiv_q - 16'd1);
    assign w_bit_end = (baud_cnt_q == w_dlim_m1);

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        baud_cnt_d = baud_cnt_q;
        wdiv_d     = wdiv_q;
        w_pop      = 1'b0;
        w_done_set = 1'b0;
        if (state_q != ST_IDLE) begin
            baud_cnt_d = w_bit_end ? 16'd0 : (baud_cnt_q + 16'd1);
        end
        unique case (state_q)
            ST_IDLE: begin
                if (ctrl_en_q && !w_empty) begin
                    w_pop      = 1'b1;
                    shreg_d    = w_fifo_dout;
                    wdiv_d     = div_q;
                    baud_cnt_d = 16'd0;
                    state_d    = ST_START;
                end
            end
            ST_START: begin
                if (w_bit_end) begin
                    bit_cnt_d = 3'd0;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_bit_end) begin
                    shreg_d   = {1'b0, shreg_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (w_bit_end) begin
                    w_done_set = w_empty;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ctrl_en_d  = ctrl_en_q;
        ctrl_ien_d = ctrl_ien_q;
        div_d      = div_q;
        done_d     = done_q;
        ovf_d      = ovf_q;
        if (w_wr_ctrl) begin
            ctrl_en_d  = Din[CTRL_EN];
            ctrl_ien_d = Din[CTRL_IEN];
        end
        if (w_wr_div)                       div_d = Din[15:0];
        if (w_ovf_set)                      ovf_d = 1'b1;
        if (w_wr_stat && Din[STAT_OVF])     ovf_d = 1'b0;
        // Clearing is applied last so it wins over a same-cycle set.
        if (w_done_set)                     done_d = 1'b1;
        if (w_wr_data || (w_wr_stat && Din[STAT_DONE])) done_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            shreg_q    <= 8'd0;
            bit_cnt_q  <= 3'd0;
            baud_cnt_q <= 16'd0;
            wdiv_q     <= DIV_RESET;
            div_q      <= DIV_RESET;
            ctrl_en_q  <= 1'b0;
            ctrl_ien_q <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            baud_cnt_q <= baud_cnt_d;
            wdiv_q     <= wdiv_d;
            div_q      <= div_d;
            ctrl_en_q  <= ctrl_en_d;
            ctrl_ien_q <= ctrl_ien_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
        end
    end

    always_comb begin
        txd = 1'b1;
        case (state_q)
            ST_START: txd = 1'b0;
            ST_DATA:  txd = shreg_q[0];
            default:  txd = 1'b1;
        endcase
    end

    assign IRQ = ctrl_ien_q && done_q;

    always_comb begin
        w_stat             = '0;
        w_stat[STAT_BUSY]  = (state_q != ST_IDLE);
        w_stat[STAT_FULL]  = w_full;
        w_stat[STAT_EMPTY] = w_empty;
        w_stat[STAT_DONE]  = done_q;
        w_stat[STAT_OVF]   = ovf_q;
        Dout = 32'd0;
        case (Addr[3:2])
            UART_CTRL: Dout = {30'd0, ctrl_ien_q, ctrl_en_q};
            UART_STAT: Dout = {27'd0, w_stat};
            UART_DIV:  Dout = {16'd0, div_q};
            default:   Dout = 32'd0;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_dev.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_tx_dev
// Brief   : Directed stimulus with a frame scoreboard decoding txd.
// Revision: 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_tx_dev;
    import uart_tx_dev_pkg::*;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic        WE    = 1'b0;
    logic [31:2] Addr  = '0;
    logic [31:0] Din   = '0;
    logic [31:0] Dout;
    logic        IRQ;
    logic        txd;

    always #5 clk = ~clk;

    uart_tx_dev #(
        .FIFO_DEPTH (4),
        .DIV_RESET  (16'd868)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .Addr  (Addr),
        .WE    (WE),
        .Din   (Din),
        .Dout  (Dout),
        .IRQ   (IRQ),
        .txd   (txd)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input longint act, input longint expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    typedef struct {
        logic [7:0] data;
        int         d;
        int         start_cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    logic mon_en   = 1'b1;
    logic in_frame = 1'b0;
    logic prev_txd = 1'b1;
    int   fpos, fbad;
    logic [7:0] rx;

    // Scoreboard monitor: detects start bits and checks every cycle of a frame
    always @(negedge clk) begin
        if (!mon_en) begin
            in_frame = 1'b0;
        end else if (!in_frame) begin
            if (prev_txd === 1'b1 && txd === 1'b0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_frame", 1, 0);
                end else begin
                    cur      = exp_q.pop_front();
                    in_frame = 1'b1;
                    fpos     = 1;
                    fbad     = 0;
                    rx       = 8'h00;
                    if (cur.start_cyc >= 0) chk("start_cycle", cyc, cur.start_cyc);
                end
            end
        end else begin
            int   bidx;
            logic ev;
            bidx = fpos / cur.d;
            if (bidx == 0)      ev = 1'b0;
            else if (bidx <= 8) ev = cur.data[bidx-1];
            else                ev = 1'b1;
            if (txd !== ev) fbad++;
            if (bidx >= 1 && bidx <= 8 && (fpos % cur.d) == 0) rx[bidx-1] = txd;
            fpos++;
            if (fpos == 10 * cur.d) begin
                in_frame = 1'b0;
                chk("frame_data", rx, cur.data);
                chk("frame_bit_timing_errors", fbad, 0);
            end
        end
        prev_txd = txd;
    end

    task automatic wr(input logic [1:0] a, input logic [31:0] d, output int n);
        @(negedge clk);
        Addr      = '0;
        Addr[3:2] = a;
        Din       = d;
        WE        = 1'b1;
        n         = cyc;
        @(posedge clk);
        #1;
        WE  = 1'b0;
        Din = '0;
    endtask

    task automatic rd_chk(input logic [1:0] a, input logic [31:0] expv, input string name);
        Addr      = '0;
        Addr[3:2] = a;
        #1;
        chk(name, Dout, expv);
    endtask

    task automatic goto(input int target);
        do @(negedge clk); while (cyc < target);
    endtask

    task automatic wait_done(input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            @(negedge clk);
            #2;
            if (exp_q.size() == 0 && !in_frame) break;
        end
        if (k == budget) begin
            chk("frame_wait_timeout", 1, 0);
            exp_q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, n2, m;

        // Reset values
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("reset_txd", txd, 1);
        chk("reset_irq", IRQ, 0);
        rd_chk(UART_DIV,  32'd868, "reset_div");
        rd_chk(UART_STAT, 32'h4,   "reset_stat");
        rd_chk(UART_CTRL, 32'h0,   "reset_ctrl");

        // Single byte, D=4
        wr(UART_DIV, 32'd4, n);
        wr(UART_CTRL, 32'd3, n);
        wr(UART_DATA, 32'hA5, n);
        exp_q.push_back('{8'hA5, 4, n + 2});
        goto(n + 41);
        chk("irq_before_done", IRQ, 0);
        goto(n + 42);
        chk("irq_at_done", IRQ, 1);
        rd_chk(UART_STAT, 32'hC, "stat_done");
        rd_chk(UART_DATA, 32'h0, "data_reads_zero");

        // Interrupt clear via STAT W1C
        wr(UART_STAT, 32'h8, m);
        goto(m + 1);
        chk("irq_w1c", IRQ, 0);
        rd_chk(UART_STAT, 32'h4, "stat_after_w1c");

        // Second frame raises done again; a DATA write clears it
        wr(UART_DATA, 32'h3C, n);
        exp_q.push_back('{8'h3C, 4, n + 2});
        goto(n + 42);
        chk("irq_second_frame", IRQ, 1);
        wr(UART_CTRL, 32'd2, m);
        wr(UART_DATA, 32'h11, m);
        goto(m + 1);
        rd_chk(UART_STAT, 32'h0, "stat_data_clears_done");
        chk("irq_data_clear", IRQ, 0);

        // Overflow with en=0, then four back-to-back frames at D=2
        wr(UART_DATA, 32'h22, m);
        wr(UART_DATA, 32'h33, m);
        wr(UART_DATA, 32'h44, m);
        wr(UART_DATA, 32'h55, m);
        goto(m + 1);
        rd_chk(UART_STAT, 32'h12, "stat_full_ovf");
        wr(UART_DIV, 32'd2, m);
        wr(UART_CTRL, 32'd1, m);
        exp_q.push_back('{8'h11, 2, m + 2});
        exp_q.push_back('{8'h22, 2, m + 23});
        exp_q.push_back('{8'h33, 2, m + 44});
        exp_q.push_back('{8'h44, 2, m + 65});
        wait_done(400);
        repeat (40) @(negedge clk);
        rd_chk(UART_STAT, 32'h1C, "stat_after_drain");
        wr(UART_STAT, 32'h18, m);
        goto(m + 1);
        rd_chk(UART_STAT, 32'h4, "stat_w1c_both");

        // DIV=0 behaves as one cycle per bit
        wr(UART_DIV, 32'd0, n);
        goto(n + 1);
        rd_chk(UART_DIV, 32'd0, "div_zero_readback");
        wr(UART_DATA, 32'h96, n);
        exp_q.push_back('{8'h96, 1, n + 2});
        wait_done(100);

        // DIV rewritten mid-frame applies to the next frame only
        wr(UART_DIV, 32'd2, n);
        wr(UART_DATA, 32'hC3, n);
        exp_q.push_back('{8'hC3, 2, n + 2});
        wr(UART_DATA, 32'h5A, n2);
        exp_q.push_back('{8'h5A, 8, n + 23});
        goto(n + 6);
        wr(UART_DIV, 32'd8, m);
        wait_done(400);

        // en cleared mid-frame: frame completes, FIFO retained
        wr(UART_DIV, 32'd2, n);
        wr(UART_DATA, 32'h0F, n);
        exp_q.push_back('{8'h0F, 2, n + 2});
        wr(UART_DATA, 32'hF0, n2);
        goto(n + 8);
        wr(UART_CTRL, 32'd0, m);
        wait_done(200);
        repeat (40) @(negedge clk);
        rd_chk(UART_STAT, 32'h0, "stat_fifo_retained");
        wr(UART_CTRL, 32'd1, m);
        exp_q.push_back('{8'hF0, 2, m + 2});
        wait_done(200);
        @(negedge clk);
        rd_chk(UART_STAT, 32'hC, "stat_after_resume");

        // Asynchronous reset in the middle of a start bit
        mon_en = 1'b0;
        wr(UART_DATA, 32'h00, n);
        goto(n + 3);
        chk("txd_start_before_reset", txd, 0);
        reset = 1'b0;
        #1;
        chk("txd_async_reset", txd, 1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("irq_after_reset", IRQ, 0);
        rd_chk(UART_DIV,  32'd868, "div_after_reset");
        rd_chk(UART_STAT, 32'h4,   "stat_after_reset");
        rd_chk(UART_CTRL, 32'h0,   "ctrl_after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
